// File: rtl/dmem_ctrl_if.sv
// dmem_ctrl_if: CPU MEM-stage bus and UART-programmer bus of the data-memory controller.
`default_nettype none

interface dmem_ctrl_if #(
  parameter int DATA_W    = 32,
  parameter int UPG_ADR_W = 15
);
  logic                 mem_read;
  logic                 mem_write;
  logic [1:0]           size;
  logic                 load_uns;
  logic [31:0]          address;
  logic [DATA_W-1:0]    write_data;
  logic [DATA_W-1:0]    read_data;
  logic                 rd_valid;
  logic                 misalign;
  logic                 prog_mode;
  logic                 upg_rst_i;
  logic                 upg_wen_i;
  logic [UPG_ADR_W-1:0] upg_adr_i;
  logic [DATA_W-1:0]    upg_dat_i;
  logic                 upg_done_i;

  modport master (
    output mem_read, mem_write, size, load_uns, address, write_data,
    output upg_rst_i, upg_wen_i, upg_adr_i, upg_dat_i, upg_done_i,
    input  read_data, rd_valid, misalign, prog_mode
  );

  modport slave (
    input  mem_read, mem_write, size, load_uns, address, write_data,
    input  upg_rst_i, upg_wen_i, upg_adr_i, upg_dat_i, upg_done_i,
    output read_data, rd_valid, misalign, prog_mode
  );
endinterface

`default_nettype wire

// File: rtl/dmem_ctrl.sv
// +-----------------------------------------------------------------------------+
// | dmem_ctrl: byte/half/word data RAM with registered loads and programmer mode |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module dmem_ctrl #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 14,
  parameter int UPG_ADR_W  = 15,
  parameter int UPG_SEL    = 14
) (
  input  logic        clock,
  input  logic        rst_n,
  dmem_ctrl_if.slave  bus
);
  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [NB-1:0] BE_BYTE = {{(NB-1){1'b0}}, 1'b1};
  localparam logic [NB-1:0] BE_HALF = {{(NB-2){1'b0}}, 2'b11};

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_PROG = 1'b1} state_t;

  state_t                 state;
  logic                   prog_mode_q;
  logic [DATA_W-1:0]      read_data_q;
  logic                   rd_valid_q;
  logic                   misalign_q;

  logic [DATA_W-1:0]      mem [0:DEPTH-1];
  logic [DATA_W-1:0]      rd_word;

  logic                   ld_pend;
  logic                   ld_bad;
  logic [1:0]             ld_size;
  logic                   ld_uns;
  logic [1:0]             ld_lane;

  logic                   run;
  logic [1:0]             lane;
  logic                   aligned;
  logic [DEPTH_LOG2-1:0]  cpu_idx;
  logic [DEPTH_LOG2-1:0]  prog_idx;
  logic                   cpu_we;
  logic                   prog_we;
  logic [NB-1:0]          cpu_be;
  logic [DATA_W-1:0]      cpu_wdat;
  logic                   ram_we;
  logic [DEPTH_LOG2-1:0]  ram_idx;
  logic [NB-1:0]          ram_be;
  logic [DATA_W-1:0]      ram_wdat;
  logic [DATA_W-1:0]      byte_shift;
  logic [DATA_W-1:0]      half_shift;
  logic [7:0]             ld_byte;
  logic [15:0]            ld_half;
  logic [DATA_W-1:0]      ld_ext;
  logic                   unused_bits;

  assign run      = (state == ST_RUN);
  assign lane     = bus.address[1:0];
  assign cpu_idx  = bus.address[DEPTH_LOG2+1:2];
  assign prog_idx = bus.upg_adr_i[DEPTH_LOG2-1:0];
  assign unused_bits = ^{bus.address[31:DEPTH_LOG2+2], bus.upg_adr_i};

  always_comb begin
    aligned = 1'b1;
    case (bus.size)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~lane[0];
      default: aligned = (lane == 2'b00);
    endcase
  end

  assign cpu_we  = run & bus.mem_write & aligned;
  assign prog_we = ~run & bus.upg_wen_i & bus.upg_adr_i[UPG_SEL];

  // Store data arrives right-aligned; steer it onto the addressed lanes.
  always_comb begin
    cpu_be   = {NB{1'b1}};
    cpu_wdat = bus.write_data;
    case (bus.size)
      2'b00: begin
        cpu_be   = BE_BYTE << lane;
        cpu_wdat = {{(DATA_W-8){1'b0}}, bus.write_data[7:0]} << {lane, 3'b000};
      end
      2'b01: begin
        cpu_be   = BE_HALF << {lane[1], 1'b0};
        cpu_wdat = {{(DATA_W-16){1'b0}}, bus.write_data[15:0]} << {lane[1], 4'b0000};
      end
      default: begin
        cpu_be   = {NB{1'b1}};
        cpu_wdat = bus.write_data;
      end
    endcase
  end

  assign ram_we   = cpu_we | prog_we;
  assign ram_idx  = run ? cpu_idx  : prog_idx;
  assign ram_be   = run ? cpu_be   : {NB{1'b1}};
  assign ram_wdat = run ? cpu_wdat : bus.upg_dat_i;

  // Non-blocking read alongside the write gives read-before-write on a shared index.
  always_ff @(posedge clock) begin
    if (ram_we) begin
      for (int b = 0; b < NB; b++) begin
        if (ram_be[b]) begin
          mem[ram_idx][b*8 +: 8] <= ram_wdat[b*8 +: 8];
        end
      end
    end
    rd_word <= mem[cpu_idx];
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      prog_mode_q <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (!bus.upg_rst_i && !bus.upg_done_i) begin
            state       <= ST_PROG;
            prog_mode_q <= 1'b1;
          end
        end
        default: begin
          if (bus.upg_rst_i || bus.upg_done_i) begin
            state       <= ST_RUN;
            prog_mode_q <= 1'b0;
          end
        end
      endcase
    end
  end

  always_comb begin
    byte_shift = rd_word >> {ld_lane, 3'b000};
    half_shift = rd_word >> {ld_lane[1], 4'b0000};
    ld_byte    = byte_shift[7:0];
    ld_half    = half_shift[15:0];
    ld_ext     = rd_word;
    case (ld_size)
      2'b00:   ld_ext = ld_uns ? {{(DATA_W-8){1'b0}}, ld_byte}
                               : {{(DATA_W-8){ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = ld_uns ? {{(DATA_W-16){1'b0}}, ld_half}
                               : {{(DATA_W-16){ld_half[15]}}, ld_half};
      default: ld_ext = rd_word;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      ld_pend     <= 1'b0;
      ld_bad      <= 1'b0;
      ld_size     <= 2'b00;
      ld_uns      <= 1'b0;
      ld_lane     <= 2'b00;
      misalign_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      read_data_q <= '0;
    end else begin
      ld_pend    <= run & bus.mem_read;
      ld_bad     <= run & bus.mem_read & ~aligned;
      ld_size    <= bus.size;
      ld_uns     <= bus.load_uns;
      ld_lane    <= lane;
      misalign_q <= run & (bus.mem_read | bus.mem_write) & ~aligned;
      rd_valid_q <= ld_pend;
      // A load accepted just before entering PROG still completes with its data.
      if (ld_pend) begin
        read_data_q <= ld_bad ? '0 : ld_ext;
      end else if (!run) begin
        read_data_q <= '0;
      end
    end
  end

  assign bus.read_data = read_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.misalign  = misalign_q;
  assign bus.prog_mode = prog_mode_q;

endmodule

`default_nettype wire
